// File: rtl/hid_report_hub_if.sv
// Forwarded-report stream between hid_report_hub and its consumer.
// The master drives the report, its channel tag and valid; the slave answers with ready.
interface hid_report_hub_if #(
  parameter int C_report_bytes = 8,
  parameter int C_chan_bits    = 3
);
  logic [C_report_bytes*8-1:0] out_report;
  logic [C_chan_bits-1:0]      out_channel;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output out_report, output out_channel, output out_valid, input out_ready);
  modport slave  (input out_report, input out_channel, input out_valid, output out_ready);
endinterface

// File: rtl/hid_report_hub.sv
// HID report hub: per-channel shadow/display capture, round-robin forwarding, stale/overrun flags.
// Define HID_REPORT_HUB_CHANGE_FILTER_EN to forward only first or changed reports.
module hid_report_hub_lane #(
  parameter int RW = 64,
  parameter int TB = 24
) (
  input  logic          clk,
  input  logic          bus_reset,
  input  logic [RW-1:0] report,
  input  logic          valid,
  input  logic          grant,
  output logic [RW-1:0] shadow,
  output logic          pending,
  output logic          overrun,
  output logic          stale
);
  logic          capture_new;
  logic [TB-1:0] cnt, cnt_nxt;

`ifdef HID_REPORT_HUB_CHANGE_FILTER_EN
  logic seen;
  assign capture_new = valid && (!seen || (report != shadow));
  always_ff @(posedge clk)
    if (bus_reset)  seen <= 1'b0;
    else if (valid) seen <= 1'b1;
`else
  assign capture_new = valid;
`endif

  assign cnt_nxt = valid ? '0 : ((&cnt) ? cnt : cnt + TB'(1));

  always_ff @(posedge clk) begin
    if (bus_reset) begin
      shadow  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      cnt     <= '0;
      stale   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      stale <= &cnt_nxt;
      if (valid) shadow <= report;
      // a capture on the granted edge re-arms pending: the grant took the old shadow
      if (capture_new)     pending <= 1'b1;
      else if (grant)      pending <= 1'b0;
      if (capture_new && pending && !grant) overrun <= 1'b1;
    end
  end
endmodule

module hid_report_hub #(
  parameter int C_channels     = 2,
  parameter int C_report_bytes = 8,
  parameter int C_disp_bytes   = 8,
  parameter int C_timeout_bits = 24,
  parameter int C_chan_bits    = 3
) (
  input  logic                                clk,
  input  logic                                bus_reset,
  input  logic [C_channels*C_report_bytes*8-1:0] hid_report,
  input  logic [C_channels-1:0]               hid_valid,
  output logic [C_channels*C_disp_bytes*8-1:0] display,
  output logic [C_channels-1:0]               stale,
  output logic [C_channels-1:0]               overrun,
  hid_report_hub_if.master                    stream
);
  localparam int RW = C_report_bytes*8;
  localparam int DW = C_disp_bytes*8;

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [C_channels-1:0][RW-1:0] shadow;
  logic [C_channels-1:0]         pending, grant;
  logic [C_chan_bits-1:0]        rr_ptr, sel, chan_q;
  logic [RW-1:0]                 rep_q;
  logic                          found, load;
  state_t                        state, state_nxt;

  for (genvar k = 0; k < C_channels; k++) begin : g_lane
    hid_report_hub_lane #(.RW(RW), .TB(C_timeout_bits)) u_lane (
      .clk      (clk),
      .bus_reset(bus_reset),
      .report   (hid_report[k*RW +: RW]),
      .valid    (hid_valid[k]),
      .grant    (grant[k]),
      .shadow   (shadow[k]),
      .pending  (pending[k]),
      .overrun  (overrun[k]),
      .stale    (stale[k])
    );
    assign display[k*DW +: DW] = shadow[k][DW-1:0];
  end

  // round-robin search starting at rr_ptr; lowest offset wins
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = C_channels-1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= C_channels) idx = idx - C_channels;
      if (pending[idx]) begin
        sel   = C_chan_bits'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk)
    if (bus_reset) state <= IDLE;
    else           state <= state_nxt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:
        if (found) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      PRESENT:
        if (stream.out_ready) begin
          if (found) load = 1'b1;
          else       state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant = load ? (C_channels'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (bus_reset) begin
      rep_q  <= '0;
      chan_q <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      rep_q  <= shadow[sel];
      chan_q <= sel;
      rr_ptr <= (sel == C_chan_bits'(C_channels-1)) ? '0 : sel + C_chan_bits'(1);
    end
  end

  assign stream.out_report  = rep_q;
  assign stream.out_channel = chan_q;
  assign stream.out_valid   = (state == PRESENT);
endmodule

// File: tb/tb_hid_report_hub.sv
// Directed bench for hid_report_hub: scoreboard of expected {channel, report} transfers
// plus immediate checks of hold, arbitration, overrun, staleness and reset behaviour.
module tb_hid_report_hub;
  localparam int C  = 2;
  localparam int R  = 8;
  localparam int D  = 8;
  localparam int T  = 4;
  localparam int CB = 3;
  localparam int RW = R*8;

  logic              clk = 1'b0;
  logic              bus_reset;
  logic [C*RW-1:0]   hid_report;
  logic [C-1:0]      hid_valid;
  logic [C*D*8-1:0]  display;
  logic [C-1:0]      stale, overrun;

  hid_report_hub_if #(.C_report_bytes(R), .C_chan_bits(CB)) sif();

  hid_report_hub #(
    .C_channels(C), .C_report_bytes(R), .C_disp_bytes(D),
    .C_timeout_bits(T), .C_chan_bits(CB)
  ) dut (
    .clk       (clk),
    .bus_reset (bus_reset),
    .hid_report(hid_report),
    .hid_valid (hid_valid),
    .display   (display),
    .stale     (stale),
    .overrun   (overrun),
    .stream    (sif.master)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  bit               sb_en  = 1'b0;
  logic [CB+RW-1:0] sbq[$];
  logic [CB+RW-1:0] sb_exp;
  logic [CB-1:0]    prev_ch;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [C-1:0] v, input logic [RW-1:0] r0, input logic [RW-1:0] r1);
    hid_valid  = v;
    hid_report = {r1, r0};
    tick();
    hid_valid  = '0;
  endtask

  task automatic push(input int ch, input logic [RW-1:0] rep);
    sbq.push_back({CB'(ch), rep});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || sif.out_valid) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_queue", 128'(sbq.size()), 128'(0));
    chk("drain_valid", 128'(sif.out_valid), 128'(0));
  endtask

  // transfer happens at the next rising edge; compare while the beat is stable
  always @(negedge clk) begin
    if (sb_en && !bus_reset && sif.out_valid && sif.out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected: observed ch%0d %0h expected no transfer",
               sif.out_channel, sif.out_report);
      end else begin
        sb_exp = sbq.pop_front();
        assert ({sif.out_channel, sif.out_report} === sb_exp) else begin
          errors++;
          $error("FAIL sb_transfer: observed %0h expected %0h",
                 {sif.out_channel, sif.out_report}, sb_exp);
        end
      end
    end
  end

  initial begin
    bus_reset     = 1'b1;
    hid_valid     = '0;
    hid_report    = '0;
    sif.out_ready = 1'b0;
    repeat (3) tick();
    bus_reset = 1'b0;
    chk("rst_valid",   128'(sif.out_valid), 128'(0));
    chk("rst_report",  128'(sif.out_report), 128'(0));
    chk("rst_channel", 128'(sif.out_channel), 128'(0));
    chk("rst_display", 128'(display), 128'(0));
    chk("rst_overrun", 128'(overrun), 128'(0));
    chk("rst_stale",   128'(stale), 128'(0));

    // first report equal to reset shadow is still forwarded
    cap(2'b01, 64'h0, 64'h0);
    chk("first_no_valid_yet", 128'(sif.out_valid), 128'(0));
    chk("first_display", 128'(display), 128'(0));
    tick();
    chk("first_beat", 128'({sif.out_valid, sif.out_channel, sif.out_report}), 128'({1'b1, 3'd0, 64'h0}));
    push(0, 64'h0);
    sb_en = 1'b1;
    sif.out_ready = 1'b1;
    tick();
    chk("first_consumed", 128'(sif.out_valid), 128'(0));
    sif.out_ready = 1'b0;

    // hold under backpressure, then back-to-back reload
    push(0, 64'h11);
    push(1, 64'h22);
    cap(2'b01, 64'h11, 64'h0);
    cap(2'b10, 64'h11, 64'h22);
    chk("display_both", 128'(display), {64'h22, 64'h11});
    for (int i = 0; i < 10; i++) begin
      chk("hold_beat", 128'({sif.out_valid, sif.out_channel, sif.out_report}), 128'({1'b1, 3'd0, 64'h11}));
      tick();
    end
    sif.out_ready = 1'b1;
    tick();
    chk("no_bubble", 128'({sif.out_valid, sif.out_channel, sif.out_report}), 128'({1'b1, 3'd1, 64'h22}));
    tick();
    chk("after_b2b_idle", 128'(sif.out_valid), 128'(0));

    // repeated identical reports
    for (int i = 0; i < 3; i++) begin
`ifndef HID_REPORT_HUB_CHANGE_FILTER_EN
      push(1, 64'h22);
`endif
      cap(2'b10, 64'h0, 64'h22);
      repeat (3) tick();
    end
    drain();
    chk("repeat_overrun", 128'(overrun), 128'(0));

    // both channels every cycle: strict alternation and overrun on both
    sb_en   = 1'b0;
    prev_ch = '0;
    for (int i = 0; i < 12; i++) begin
      cap(2'b11, 64'h100 + 64'(i), 64'h200 + 64'(i));
      if (i >= 1) chk("alt_valid", 128'(sif.out_valid), 128'(1));
      if (i >= 2) chk("alt_channel", 128'(sif.out_channel), 128'(prev_ch ^ 3'd1));
      prev_ch = sif.out_channel;
    end
    chk("alt_overrun", 128'(overrun), 128'(2'b11));
    drain();

    // staleness
    cap(2'b11, 64'h1, 64'h2);
    chk("stale_cleared", 128'(stale), 128'(0));
    repeat (11) tick();
    chk("stale_not_yet", 128'(stale), 128'(0));
    repeat (4) tick();
    chk("stale_set", 128'(stale), 128'(2'b11));
    cap(2'b10, 64'h1, 64'h3);
    chk("stale_ch1_clear", 128'(stale), 128'(2'b01));
    drain();

    // reset while a beat is stalled
    sif.out_ready = 1'b0;
    cap(2'b01, 64'h55, 64'h3);
    tick();
    chk("pre_reset_valid", 128'(sif.out_valid), 128'(1));
    chk("pre_reset_overrun", 128'(overrun), 128'(2'b11));
    bus_reset = 1'b1;
    tick();
    chk("mid_rst_valid",   128'(sif.out_valid), 128'(0));
    chk("mid_rst_display", 128'(display), 128'(0));
    chk("mid_rst_overrun", 128'(overrun), 128'(0));
    chk("mid_rst_stale",   128'(stale), 128'(0));
    bus_reset = 1'b0;

    sb_en = 1'b1;
    push(0, 64'h0);
    sif.out_ready = 1'b1;
    cap(2'b01, 64'h0, 64'h0);
    tick();
    chk("post_rst_first", 128'({sif.out_valid, sif.out_channel, sif.out_report}), 128'({1'b1, 3'd0, 64'h0}));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
